// File: rtl/field_adder_arbiter_pkg.sv
// Shared definitions for the field adder arbiter: FSM state encoding and
// the field arithmetic constants (element width and modulus).
package field_adder_arbiter_pkg;

  // Field elements are F_NBITS wide and always held in [0, FIELD_Q).
  localparam int F_NBITS = 16;
  localparam logic [F_NBITS-1:0] FIELD_Q = 16'd65521;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/field_adder_arbiter_adder.sv
// field_adder: two-stage modular adder, c = (a + b) mod FIELD_Q.
// o_ready drops when a new operation is launched and rises two cycles after
// i_en, then stays high until the next launch.
module field_adder
  import field_adder_arbiter_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rstb,
  input  logic               i_en,
  input  logic [F_NBITS-1:0] i_a,
  input  logic [F_NBITS-1:0] i_b,
  output logic [F_NBITS-1:0] o_c,
  output logic               o_ready
);

  logic [F_NBITS:0]   r_sum;
  logic               r_v1;
  logic [F_NBITS-1:0] r_c;
  logic               r_ready;
  logic [F_NBITS-1:0] w_red;

  // Both inputs are below FIELD_Q, so a single conditional subtract reduces;
  // the difference fits in F_NBITS bits whenever it is selected.
  assign w_red = r_sum[F_NBITS-1:0] - FIELD_Q;

  // Stage 1 forms the raw sum, stage 2 reduces it and raises ready.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_sum   <= '0;
      r_v1    <= 1'b0;
      r_c     <= '0;
      r_ready <= 1'b0;
    end else begin
      r_v1 <= i_en;
      if (i_en) begin
        r_sum <= {1'b0, i_a} + {1'b0, i_b};
      end
      if (i_en) begin
        r_ready <= 1'b0;
      end else if (r_v1) begin
        r_ready <= 1'b1;
        r_c     <= (r_sum >= {1'b0, FIELD_Q}) ? w_red : r_sum[F_NBITS-1:0];
      end
    end
  end

  assign o_c     = r_c;
  assign o_ready = r_ready;

endmodule

// File: rtl/field_adder_arbiter_pick.sv
// arb_rr_pick: combinational round-robin winner selection.
// Scans requests starting at i_ptr+1 and wrapping from nReq-1 to 0.
// With FIELD_ADDER_ARB_PRIO0_EN defined, requester 0 overrides the scan.
module arb_rr_pick #(
  parameter int nReq     = 4,
  parameter int nReqBits = $clog2(nReq)
) (
  input  logic [nReq-1:0]     i_req,
  input  logic [nReqBits-1:0] i_ptr,
  output logic [nReqBits-1:0] o_winner,
  output logic                o_valid
);

  int                  w_idx;
  logic [nReqBits-1:0] w_idx_b;

  // First asserted request after the pointer wins; optional prio-0 override.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    w_idx_b  = '0;
    for (int i = 1; i <= nReq; i++) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= nReq) begin
        w_idx = w_idx - nReq;
      end
      w_idx_b = nReqBits'(w_idx);
      if (!o_valid && i_req[w_idx_b]) begin
        o_valid  = 1'b1;
        o_winner = w_idx_b;
      end
    end
`ifdef FIELD_ADDER_ARB_PRIO0_EN
    if (i_req[0]) begin
      o_valid  = 1'b1;
      o_winner = '0;
    end
`endif
  end

endmodule

// File: rtl/field_adder_arbiter.sv
// field_adder_arbiter: shares one field_adder among nReq requesters.
// Requests are level signals held until a one-cycle ack; the arbiter grants
// round-robin, launches one modular add and returns the sum on o_c_out.
// Optional macro FIELD_ADDER_ARB_PRIO0_EN: requester 0 gets strict priority
// and serving it leaves the round-robin pointer untouched.
//
//  state   | meaning
//  ST_IDLE | no op in flight; arbitrate and latch the winner's operands
//  ST_WAIT | adder running; wait for a fresh ready, latch result
//  ST_ACK  | pulse ack for the granted requester for one cycle
module field_adder_arbiter
  import field_adder_arbiter_pkg::*;
#(
  parameter int nReq     = 4,
  parameter int nReqBits = $clog2(nReq)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [nReq-1:0]                 i_req,
  input  logic [nReq-1:0][F_NBITS-1:0]    i_a_in,
  input  logic [nReq-1:0][F_NBITS-1:0]    i_b_in,
  output logic [nReq-1:0]                 o_ack,
  output logic [F_NBITS-1:0]              o_c_out,
  output logic [nReqBits-1:0]             o_grant,
  output logic                            o_busy
);

  if (nReq < 2) begin : g_bad_nreq
    $error("field_adder_arbiter: nReq must be at least 2");
  end
  if (nReqBits != $clog2(nReq)) begin : g_bad_nreqbits
    $error("field_adder_arbiter: nReqBits is derived from nReq and must not be overridden");
  end

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [nReqBits-1:0] r_ptr;
  logic [nReqBits-1:0] r_grant;
  logic [F_NBITS-1:0]  r_op_a;
  logic [F_NBITS-1:0]  r_op_b;
  logic                r_en_add;
  logic [F_NBITS-1:0]  r_c_out;

  logic [nReqBits-1:0] w_pick;
  logic                w_pick_valid;
  logic [F_NBITS-1:0]  w_add_c;
  logic                w_add_ready;
  logic                w_add_done;
  logic                w_rst_b;

  assign w_rst_b = ~i_rst;

  arb_rr_pick #(
    .nReq     (nReq),
    .nReqBits (nReqBits)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  field_adder u_add (
    .i_clk   (i_clk),
    .i_rstb  (w_rst_b),
    .i_en    (r_en_add),
    .i_a     (r_op_a),
    .i_b     (r_op_b),
    .o_c     (w_add_c),
    .o_ready (w_add_ready)
  );

  // Ready is still high from the previous op during the launch cycle, so it
  // only counts once the launch pulse has gone.
  assign w_add_done = ~r_en_add & w_add_ready;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_valid) w_next = ST_WAIT;
      ST_WAIT: if (w_add_done)   w_next = ST_ACK;
      ST_ACK:                    w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // Grant/operand capture, adder launch pulse, result and pointer update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr    <= nReqBits'(nReq - 1);
      r_grant  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_en_add <= 1'b0;
      r_c_out  <= '0;
    end else begin
      r_en_add <= 1'b0;
      if (r_state == ST_IDLE && w_pick_valid) begin
        r_grant  <= w_pick;
        r_op_a   <= i_a_in[w_pick];
        r_op_b   <= i_b_in[w_pick];
        r_en_add <= 1'b1;
      end
      if (r_state == ST_WAIT && w_add_done) begin
        r_c_out <= w_add_c;
`ifdef FIELD_ADDER_ARB_PRIO0_EN
        if (r_grant != '0) begin
          r_ptr <= r_grant;
        end
`else
        r_ptr <= r_grant;
`endif
      end
    end
  end

  // One-hot ack for the served requester while in ST_ACK.
  always_comb begin
    o_ack = '0;
    if (r_state == ST_ACK) begin
      o_ack[r_grant] = 1'b1;
    end
  end

  assign o_c_out = r_c_out;
  assign o_grant = r_grant;
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_field_adder_arbiter.sv
// Directed testbench for field_adder_arbiter (nReq = 4, adder latency 2,
// so a request seen in ST_IDLE is acked after 4 clock edges).
// The prio-0 scenario runs only when FIELD_ADDER_ARB_PRIO0_EN is defined.
module tb_field_adder_arbiter;
  import field_adder_arbiter_pkg::*;

  localparam int N = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [N-1:0]               req = '0;
  logic [N-1:0][F_NBITS-1:0]  a_in = '0;
  logic [N-1:0][F_NBITS-1:0]  b_in = '0;
  logic [N-1:0]               ack;
  logic [F_NBITS-1:0]         c_out;
  logic [1:0]                 grant;
  logic                       busy;

  int n_checks = 0;
  int n_pass   = 0;

  field_adder_arbiter #(.nReq(N)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_a_in  (a_in),
    .i_b_in  (b_in),
    .o_ack   (ack),
    .o_c_out (c_out),
    .o_grant (grant),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until an ack appears (bounded); ackv stays 0 on timeout.
  task automatic wait_ack(output logic [N-1:0] ackv, output int lat);
    ackv = '0;
    lat  = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      lat = k + 1;
      if (|ack) begin
        ackv = ack;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] av;
    logic [N-1:0] acc;
    int           lat;
    int           seq [7];

    // Reset state
    step(2);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_c", 32'(c_out), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // T1: single request, latency, operand change after grant ignored
    a_in[2] = 16'd5;
    b_in[2] = 16'd7;
    req[2]  = 1'b1;
    step(1);
    chk("t1_busy", 32'(busy), 32'd1);
    a_in[2] = 16'd999;
    wait_ack(av, lat);
    chk("t1_lat", 32'(lat + 1), 32'd4);
    chk("t1_ack", 32'(av), 32'b0100);
    chk("t1_c", 32'(c_out), 32'd12);
    chk("t1_grant", 32'(grant), 32'd2);
    req[2] = 1'b0;
    step(1);
    chk("t1_pulse", 32'(ack), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // T2: modular wrap, result holds
    a_in[0] = FIELD_Q - 16'd1;
    b_in[0] = 16'd2;
    req[0]  = 1'b1;
    wait_ack(av, lat);
    chk("t2_ack", 32'(av), 32'b0001);
    chk("t2_c", 32'(c_out), 32'd1);
    req[0] = 1'b0;
    step(5);
    chk("t2_hold", 32'(c_out), 32'd1);

    // T3: all requesting from reset, served in order 0..3
    rst = 1'b1;
    #2;
    chk("t3_rst_c", 32'(c_out), 32'd0);
    for (int i = 0; i < N; i++) begin
      a_in[i] = 16'(i * 10);
      b_in[i] = 16'd1;
    end
    req = '1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      wait_ack(av, lat);
      chk($sformatf("t3_ack%0d", k), 32'(av), 32'd1 << k);
      chk($sformatf("t3_c%0d", k), 32'(c_out), 32'(k * 10 + 1));
      req = req & ~av;
    end
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      acc = acc | ack;
    end
    chk("t3_no_extra", 32'(acc), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // T4: serve 2, then 1 and 3 together -> 3 first (wrap)
    a_in[2] = 16'd1000;  b_in[2] = 16'd2000;
    a_in[3] = 16'd65000; b_in[3] = 16'd600;
    a_in[1] = 16'd7;     b_in[1] = 16'd8;
    req[2] = 1'b1;
    wait_ack(av, lat);
    chk("t4_ack2", 32'(av), 32'b0100);
    chk("t4_c2", 32'(c_out), 32'd3000);
    req[2] = 1'b0;
    step(1);
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_ack(av, lat);
    chk("t4_first", 32'(av), 32'b1000);
    chk("t4_c3", 32'(c_out), 32'd79);
    req[3] = 1'b0;
    wait_ack(av, lat);
    chk("t4_second", 32'(av), 32'b0010);
    chk("t4_c1", 32'(c_out), 32'd15);
    req[1] = 1'b0;
    step(2);

    // T5: reset during ST_WAIT, then pointer back at nReq-1
    a_in[1] = 16'd100; b_in[1] = 16'd200;
    a_in[3] = 16'd5;   b_in[3] = 16'd6;
    req[1] = 1'b1;
    step(1);
    chk("t5_wait_busy", 32'(busy), 32'd1);
    step(1);
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_c", 32'(c_out), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    req[3] = 1'b1;
    step(1);
    chk("t5_ack_rst", 32'(ack), 32'd0);
    rst = 1'b0;
    wait_ack(av, lat);
    chk("t5_lat", 32'(lat), 32'd4);
    chk("t5_ack1", 32'(av), 32'b0010);
    chk("t5_c1", 32'(c_out), 32'd300);
    req[1] = 1'b0;
    wait_ack(av, lat);
    chk("t5_ack3", 32'(av), 32'b1000);
    chk("t5_c3", 32'(c_out), 32'd11);
    req[3] = 1'b0;
    step(2);

`ifdef FIELD_ADDER_ARB_PRIO0_EN
    // T6: requester 0 interleaves between every round-robin grant
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    seq = '{1, 0, 2, 0, 1, 0, 2};
    req = 4'b0110;
    for (int k = 0; k < 7; k++) begin
      wait_ack(av, lat);
      chk($sformatf("t6_ack%0d", k), 32'(av), 32'd1 << seq[k]);
      req[0] = av[0] ? 1'b0 : 1'b1;
    end
    req = '0;
    step(6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
